// File: rtl/bcd_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// bcd_serial_adder_pkg
// Shared definitions for the digit-serial BCD adder:
//   - state_t      : controller states (IDLE, RUN, DONE)
//   - DIGIT_MAX    : largest legal BCD digit (9)
//   - DEC_ADJ      : decimal adjust added to a binary digit sum above 9 (6)
//   - digit_invalid: true when a 4-bit code is not a legal BCD digit
// -----------------------------------------------------------------------------
package bcd_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] DEC_ADJ   = 4'd6;

    // Flags the codes 10..15, which have no meaning in packed BCD.
    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_adder_digit_add.sv
// -----------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit decimal adder.
// Ports:
//   x, y   in  4  BCD digits to add
//   cin    in  1  decimal carry from the lower digit
//   digit  out 4  BCD result digit
//   cout   out 1  decimal carry into the next digit
// -----------------------------------------------------------------------------
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    // Five bits hold the largest possible binary sum 9 + 9 + 1 = 19.
    logic [4:0] sum5_s;

    // Binary digit sum, then decimal adjust when the sum leaves the 0..9 range.
    always_comb begin
        sum5_s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        digit  = sum5_s[3:0];
        cout   = 1'b0;
        if (sum5_s > {1'b0, DIGIT_MAX}) begin
            // Adding 6 modulo 16 skips the six unused codes A..F.
            digit = sum5_s[3:0] + DEC_ADJ;
            cout  = 1'b1;
        end else begin
            digit = sum5_s[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// bcd_serial_adder
// Adds two packed-BCD operands one digit per clock, least significant first,
// using a single shared bcd_digit_add.
// Parameters:
//   NDIG   digits per operand (1..16)
// Ports:
//   clk    in  1        rising-edge clock
//   rst    in  1        asynchronous active-high reset
//   start  in  1        add request, accepted in IDLE or DONE
//   a, b   in  4*NDIG   packed BCD operands, digit 0 in bits [3:0]
//   sum    out 4*NDIG   packed BCD result (registered, held until next accept)
//   cout   out 1        decimal carry out of the top digit (registered)
//   busy   out 1        high while digits are being processed
//   done   out 1        one-cycle pulse when sum/cout are final
//   err    out 1        operand digit above 9 seen (only with BCD_DIGIT_CHECK_EN)
// Build option:
//   `define BCD_DIGIT_CHECK_EN to add the err port and its digit checker.
// -----------------------------------------------------------------------------
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              busy,
    output logic              done
`ifdef BCD_DIGIT_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int W  = 4 * NDIG;
    // Digit index width; a one-digit adder still needs a 1-bit index.
    localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    state_t          state_r;
    state_t          state_nx_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic            cout_r;
    logic            carry_r;
    logic            busy_r;
    logic            done_r;
    logic [KW-1:0]   k_r;

    logic            accept_s;
    logic            last_s;
    logic [KW+1:0]   base_s;
    logic [3:0]      xa_s;
    logic [3:0]      yb_s;
    logic [3:0]      dig_s;
    logic            cy_s;

    // Start is honoured only when no addition is in flight.
    always_comb begin
        accept_s = 1'b0;
        if (start && ((state_r == IDLE) || (state_r == DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Digit selection from the latched operands by the current index.
    always_comb begin
        last_s = (k_r == K_LAST);
        base_s = {k_r, 2'b00};
        xa_s   = a_r[base_s +: 4];
        yb_s   = b_r[base_s +: 4];
    end

    bcd_digit_add u_digit_add (
        .x     (xa_s),
        .y     (yb_s),
        .cin   (carry_r),
        .digit (dig_s),
        .cout  (cy_s)
    );

    // Controller next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                // A start in DONE chains straight into the next addition.
                if (start) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand latch, digit accumulation and carry/index bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            carry_r <= 1'b0;
            k_r     <= '0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            carry_r <= 1'b0;
            k_r     <= '0;
        end else if (state_r == RUN) begin
            sum_r[base_s +: 4] <= dig_s;
            carry_r            <= cy_s;
            if (last_s) begin
                cout_r <= cy_s;
                k_r    <= '0;
            end else begin
                k_r    <= k_r + K_ONE;
            end
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == RUN);
            done_r <= (state_nx_s == DONE);
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic err_r;

    // Sticky flag for any illegal digit seen while processing this addition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (accept_s) begin
            err_r <= 1'b0;
        end else if (state_r == RUN) begin
            err_r <= err_r | digit_invalid(xa_s) | digit_invalid(yb_s);
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`endif

    assign sum  = sum_r;
    assign cout = cout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
